// File: rtl/pci_target_seq_pkg.sv
// rtl/pci_target_seq_pkg.sv - shared PCI command codes and sequencer state encoding
package pci_target_seq_pkg;

    // Target sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_DATA,
        ST_BACKOFF,
        ST_TURNOFF
    } state_t;

    // Memory commands this target responds to
    localparam logic [3:0] CMD_MEM_READ      = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE     = 4'b0111;
    localparam logic [3:0] CMD_MEM_READ_MULT = 4'b1100;
    localparam logic [3:0] CMD_MEM_READ_LINE = 4'b1110;
    localparam logic [3:0] CMD_MEM_WRITE_INV = 4'b1111;

    // One bit per command code: set if the command is claimed by a memory BAR
    localparam logic [15:0] IS_MEMCMD = (16'h1 << CMD_MEM_READ)
                                      | (16'h1 << CMD_MEM_WRITE)
                                      | (16'h1 << CMD_MEM_READ_MULT)
                                      | (16'h1 << CMD_MEM_READ_LINE)
                                      | (16'h1 << CMD_MEM_WRITE_INV);

    // One bit per command code: set if the command moves data toward the target
    localparam logic [15:0] IS_WRITE = (16'h1 << CMD_MEM_WRITE)
                                     | (16'h1 << CMD_MEM_WRITE_INV);

endpackage

// File: rtl/pci_wait_timer.sv
// rtl/pci_wait_timer.sv - data-phase wait-state down-counter flagging a target timeout
module pci_wait_timer #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(MAX_WAIT) + 1;

    logic [W-1:0] count;

    // Reload on every TRDY or outside the data state, count down each wait clock
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= W'(MAX_WAIT - 1);
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // Flag during the last allowed wait clock so STOP# follows right after it
    assign expired = en && (count == '0);

endmodule

// File: rtl/pci_target_seq.sv
// rtl/pci_target_seq.sv - PCI target data-phase sequencer for one 32-bit memory BAR
module pci_target_seq
    import pci_target_seq_pkg::*;
#(
    parameter logic [31:0] BAR_BASE = 32'h0000_0000,
    parameter int          BAR_BITS = 12,
    parameter int          MAX_WAIT = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                FRAME_N,
    input  logic                IRDY_N,
    input  logic [31:0]         AD_IN,
    input  logic [3:0]          CBE_N_IN,
    output logic [31:0]         AD_OUT,
    output logic                AD_OE,
    output logic                DEVSEL_N,
    output logic                TRDY_N,
    output logic                STOP_N,
    output logic                CTL_OE,
    output logic                DATA_CE,
    output logic [BAR_BITS-3:0] LOC_ADDR,
    output logic                LOC_RD,
    output logic                LOC_WE,
    output logic [3:0]          LOC_BE,
    output logic [31:0]         LOC_WDATA,
    input  logic [31:0]         LOC_RDATA,
    input  logic                LOC_RDY
);

    localparam int                AW       = BAR_BITS - 2;
    localparam logic [AW-1:0]     TOP_WORD = '1;

    state_t state;
    logic   frame_q;
    logic   ignore;
    logic   is_wr;
    logic   hit;
    logic   waiting;
    logic   timeout;

    assign hit = (AD_IN[31:BAR_BITS] == BAR_BASE[31:BAR_BITS])
              && (AD_IN[1:0] == 2'b00)
              && IS_MEMCMD[CBE_N_IN];

    // A data phase is waiting on the local side while neither TRDY# nor STOP# is driven low
    assign waiting   = (state == ST_DATA) && TRDY_N && STOP_N;

    assign DATA_CE   = !IRDY_N && !TRDY_N;
    assign LOC_WE    = DATA_CE && is_wr;
    assign LOC_RD    = waiting && !is_wr;
    assign LOC_BE    = ~CBE_N_IN;
    assign LOC_WDATA = AD_IN;

    pci_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (CLK),
        .rst     (RST),
        .clear   ((state != ST_DATA) || !TRDY_N),
        .en      (waiting),
        .expired (timeout)
    );

    // Bus sequencer: claim, per-word TRDY handshake, disconnect/retry and turnaround
    always_ff @(posedge CLK) begin
        // Track FRAME# even in reset so a transaction in flight is not mistaken for a new one
        frame_q <= FRAME_N;
        if (RST) begin
            state    <= ST_IDLE;
            DEVSEL_N <= 1'b1;
            TRDY_N   <= 1'b1;
            STOP_N   <= 1'b1;
            CTL_OE   <= 1'b0;
            AD_OE    <= 1'b0;
            AD_OUT   <= '0;
            LOC_ADDR <= '0;
            is_wr    <= 1'b0;
            ignore   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ignore) begin
                        // Someone else's transaction: sit out until the bus is idle
                        if (FRAME_N && IRDY_N) begin
                            ignore <= 1'b0;
                        end
                    end else if (frame_q && !FRAME_N) begin
                        if (hit) begin
                            state    <= ST_DECODE;
                            CTL_OE   <= 1'b1;
                            is_wr    <= IS_WRITE[CBE_N_IN];
                            LOC_ADDR <= AD_IN[BAR_BITS-1:2];
                        end else begin
                            ignore <= 1'b1;
                        end
                    end
                end
                ST_DECODE: begin
                    state    <= ST_DATA;
                    DEVSEL_N <= 1'b0;
                    AD_OE    <= !is_wr;
                end
                ST_DATA: begin
                    if (!TRDY_N) begin
                        if (DATA_CE) begin
                            TRDY_N <= 1'b1;
                            if (!STOP_N) begin
                                state <= ST_BACKOFF;
                            end else if (FRAME_N) begin
                                state    <= ST_TURNOFF;
                                DEVSEL_N <= 1'b1;
                                AD_OE    <= 1'b0;
                            end else begin
                                LOC_ADDR <= LOC_ADDR + AW'(1);
                            end
                        end
                    end else if (LOC_RDY) begin
                        // Data wins over a coincident timeout
                        TRDY_N <= 1'b0;
                        if (!is_wr) begin
                            AD_OUT <= LOC_RDATA;
                        end
                        if (LOC_ADDR == TOP_WORD) begin
                            STOP_N <= 1'b0;
                        end
                    end else if (timeout) begin
                        // Retry on the first phase, disconnect otherwise; same bus signalling
                        STOP_N <= 1'b0;
                        state  <= ST_BACKOFF;
                    end
                end
                ST_BACKOFF: begin
                    if (FRAME_N) begin
                        state    <= ST_TURNOFF;
                        DEVSEL_N <= 1'b1;
                        STOP_N   <= 1'b1;
                        AD_OE    <= 1'b0;
                    end
                end
                ST_TURNOFF: begin
                    state  <= ST_IDLE;
                    CTL_OE <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_target_seq.sv
// tb/tb_pci_target_seq.sv - randomized self-checking bench for pci_target_seq
module tb_pci_target_seq;

    localparam int MAXW = 8;
    localparam int TOPW = 1023;

    logic        CLK = 1'b0;
    logic        RST, FRAME_N, IRDY_N, LOC_RDY;
    logic [31:0] AD_IN, AD_OUT, LOC_WDATA, LOC_RDATA;
    logic [3:0]  CBE_N_IN, LOC_BE;
    logic        AD_OE, DEVSEL_N, TRDY_N, STOP_N, CTL_OE, DATA_CE, LOC_RD, LOC_WE;
    logic [9:0]  LOC_ADDR;
    logic [31:0] salt;

    always #5 CLK = ~CLK;

    assign LOC_RDATA = 32'(LOC_ADDR) * 32'd3 + salt;

    pci_target_seq dut (
        .CLK (CLK), .RST (RST), .FRAME_N (FRAME_N), .IRDY_N (IRDY_N),
        .AD_IN (AD_IN), .CBE_N_IN (CBE_N_IN), .AD_OUT (AD_OUT), .AD_OE (AD_OE),
        .DEVSEL_N (DEVSEL_N), .TRDY_N (TRDY_N), .STOP_N (STOP_N), .CTL_OE (CTL_OE),
        .DATA_CE (DATA_CE), .LOC_ADDR (LOC_ADDR), .LOC_RD (LOC_RD), .LOC_WE (LOC_WE),
        .LOC_BE (LOC_BE), .LOC_WDATA (LOC_WDATA), .LOC_RDATA (LOC_RDATA), .LOC_RDY (LOC_RDY)
    );

    typedef struct {
        logic        rst, frame_n, irdy_n, rdy;
        logic [31:0] ad;
        logic [3:0]  cbe;
        logic        devsel_n, trdy_n, stop_n, ctl_oe, ad_oe, ce, we, rd;
        logic [9:0]  addr;
        logic [31:0] ad_out;
        logic        chk_out;
    } cyc_t;

    cyc_t tl[$];
    cyc_t cur;
    bit   cur_valid = 0;
    int   total = 0, bad = 0, txn = 0, cyc = 0;
    logic [3:0] cmds [5] = '{4'h6, 4'h7, 4'hC, 4'hE, 4'hF};

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c.rst = 0; c.frame_n = 1; c.irdy_n = 1; c.rdy = 1'($urandom_range(0, 1));
        c.ad = $urandom; c.cbe = 4'($urandom_range(0, 15));
        c.devsel_n = 1; c.trdy_n = 1; c.stop_n = 1; c.ctl_oe = 0; c.ad_oe = 0;
        c.ce = 0; c.we = 0; c.rd = 0; c.addr = '0; c.ad_out = '0; c.chk_out = 0;
        return c;
    endfunction

    function automatic cyc_t phase_cyc(bit fl, bit wr, logic [31:0] wd, logic [3:0] be, int a);
        cyc_t c = idle_cyc();
        c.frame_n = fl; c.irdy_n = 0; c.cbe = be;
        if (wr) c.ad = wd;
        c.devsel_n = 0; c.ctl_oe = 1; c.ad_oe = !wr; c.rd = !wr; c.addr = 10'(a);
        return c;
    endfunction

    // Builds the whole bus cycle of one master transaction with expected target outputs
    task automatic gen(input logic [31:0] addr, input logic [3:0] cmd, input int nwords,
                       input int lat_lo, input int lat_hi, input int to_word, input int rst_at);
        cyc_t c;
        bit hit, wr, fl, done;
        int a, d, w;
        logic [31:0] wd;
        logic [3:0] be;
        tl.delete();
        txn++;
        hit = (addr[31:12] == 20'h0) && (addr[1:0] == 2'b00) && (cmd inside {4'h6, 4'h7, 4'hC, 4'hE, 4'hF});
        wr  = (cmd == 4'h7) || (cmd == 4'hF);
        c = idle_cyc(); c.frame_n = 0; c.ad = addr; c.cbe = cmd; tl.push_back(c);
        if (!hit) begin
            for (int i = 0; i < nwords; i++) begin
                c = idle_cyc(); c.frame_n = (i == nwords - 1); c.irdy_n = 0; tl.push_back(c);
            end
        end else begin
            a = int'(addr[11:2]); w = 0; done = 0;
            wd = $urandom; be = 4'($urandom_range(0, 15));
            c = idle_cyc(); c.ctl_oe = 1; c.frame_n = (nwords == 1); c.irdy_n = 0; c.cbe = be;
            if (wr) c.ad = wd;
            tl.push_back(c);
            while (!done) begin
                fl = (w == nwords - 1);
                d = (w == to_word) ? MAXW : $urandom_range(lat_lo, lat_hi);
                for (int j = 0; j < MAXW; j++) begin
                    c = phase_cyc(fl, wr, wd, be, a); c.rdy = (j == d); tl.push_back(c);
                    if (j == d) break;
                end
                if (d >= MAXW) begin
                    c = phase_cyc(fl, wr, wd, be, a); c.rd = 0; c.stop_n = 0; tl.push_back(c);
                    if (!fl) begin
                        c = phase_cyc(1, wr, wd, be, a); c.rd = 0; c.stop_n = 0; tl.push_back(c);
                    end
                    done = 1;
                end else begin
                    c = phase_cyc(fl, wr, wd, be, a);
                    c.trdy_n = 0; c.rd = 0; c.ce = 1; c.we = wr; c.stop_n = (a != TOPW);
                    c.ad_out = 32'(a) * 32'd3 + salt; c.chk_out = !wr;
                    tl.push_back(c);
                    if (a == TOPW) begin
                        c = phase_cyc(1, wr, wd, be, a); c.rd = 0; c.stop_n = 0; tl.push_back(c);
                        done = 1;
                    end else if (fl) begin
                        done = 1;
                    end else begin
                        w++; a++; wd = $urandom; be = 4'($urandom_range(0, 15));
                    end
                end
            end
            c = idle_cyc(); c.ctl_oe = 1; tl.push_back(c);
        end
        repeat (2 + $urandom_range(0, 2)) tl.push_back(idle_cyc());
        if (rst_at > 0 && rst_at < tl.size()) begin
            while (tl.size() > rst_at + 1) void'(tl.pop_back());
            tl[rst_at].rst = 1;
            tl.push_back(idle_cyc());
            tl.push_back(idle_cyc());
        end
    endtask

    task automatic run();
        foreach (tl[i]) begin
            @(posedge CLK); #1;
            RST = tl[i].rst; FRAME_N = tl[i].frame_n; IRDY_N = tl[i].irdy_n;
            AD_IN = tl[i].ad; CBE_N_IN = tl[i].cbe; LOC_RDY = tl[i].rdy;
            cur = tl[i]; cyc = i; cur_valid = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Cycle-by-cycle comparison of the DUT against the expected timeline
    always @(negedge CLK) begin
        if (cur_valid) begin
            total++;
            if ({DEVSEL_N, TRDY_N, STOP_N, CTL_OE, AD_OE, DATA_CE, LOC_WE, LOC_RD} !==
                {cur.devsel_n, cur.trdy_n, cur.stop_n, cur.ctl_oe, cur.ad_oe, cur.ce, cur.we, cur.rd}) begin
                bad++;
                $display("FAIL ctl txn=%0d cyc=%0d got=%b exp=%b (devsel trdy stop ctl_oe ad_oe ce we rd)", txn, cyc,
                         {DEVSEL_N, TRDY_N, STOP_N, CTL_OE, AD_OE, DATA_CE, LOC_WE, LOC_RD},
                         {cur.devsel_n, cur.trdy_n, cur.stop_n, cur.ctl_oe, cur.ad_oe, cur.ce, cur.we, cur.rd});
            end
            if (cur.rd || cur.we) begin
                total++;
                if (LOC_ADDR !== cur.addr) begin
                    bad++;
                    $display("FAIL loc_addr txn=%0d cyc=%0d got=%0h exp=%0h", txn, cyc, LOC_ADDR, cur.addr);
                end
            end
            if (cur.chk_out) begin
                total++;
                if (AD_OUT !== cur.ad_out) begin
                    bad++;
                    $display("FAIL ad_out txn=%0d cyc=%0d got=%0h exp=%0h", txn, cyc, AD_OUT, cur.ad_out);
                end
            end
            if (cur.we) begin
                total++;
                if ({LOC_WDATA, LOC_BE} !== {cur.ad, ~cur.cbe}) begin
                    bad++;
                    $display("FAIL wdata txn=%0d cyc=%0d got=%0h/%0h exp=%0h/%0h", txn, cyc,
                             LOC_WDATA, LOC_BE, cur.ad, ~cur.cbe);
                end
            end
        end
    end

    initial begin
        logic [31:0] addr;
        logic [3:0]  cmd;
        int r, n;
        RST = 1; FRAME_N = 1; IRDY_N = 1; AD_IN = '0; CBE_N_IN = '0; LOC_RDY = 0; salt = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ctl", {29'd0, DEVSEL_N, TRDY_N, STOP_N}, 32'h7);
        chk("rst_oe", {29'd0, CTL_OE, AD_OE, LOC_RD}, 32'h0);
        chk("rst_addr", 32'(LOC_ADDR), 32'h0);
        chk("rst_ad_out", AD_OUT, 32'h0);

        // Single write to word 1
        gen(32'h4, 4'h7, 1, 0, 0, -1, 0);
        chk("m_wr_dev_n1", {31'd0, tl[1].devsel_n}, 32'h1);
        chk("m_wr_dev_n2", {31'd0, tl[2].devsel_n}, 32'h0);
        chk("m_wr_we_addr", {21'd0, tl[3].we, tl[3].addr}, 32'h401);
        chk("m_wr_ctl_n4", {31'd0, tl[4].ctl_oe}, 32'h1);
        chk("m_wr_ctl_n5", {31'd0, tl[5].ctl_oe}, 32'h0);
        run();

        // Four-word read burst from the base
        salt = 0;
        gen(32'h0, 4'h6, 4, 0, 0, -1, 0);
        chk("m_rd_w0", tl[3].ad_out, 32'd0);
        chk("m_rd_w1", tl[5].ad_out, 32'd3);
        chk("m_rd_w2", tl[7].ad_out, 32'd6);
        chk("m_rd_w3", tl[9].ad_out, 32'd9);
        chk("m_rd_gap", {31'd0, tl[4].trdy_n}, 32'h1);
        chk("m_rd_oe_off", {31'd0, tl[10].ad_oe}, 32'h0);
        run();

        // Miss just past the window
        gen(32'h1000, 4'h6, 3, 0, 0, -1, 0);
        n = 0;
        foreach (tl[i]) if (tl[i].ctl_oe || !tl[i].devsel_n) n++;
        chk("m_miss_quiet", 32'(n), 32'd0);
        run();

        // Read never ready: retry, STOP# held until FRAME# rises
        gen(32'h0, 4'h6, 2, 0, 0, 0, 0);
        chk("m_to_n9", {30'd0, tl[9].stop_n, tl[9].trdy_n}, 32'h3);
        chk("m_to_n10", {30'd0, tl[10].stop_n, tl[10].trdy_n}, 32'h1);
        chk("m_to_n11", {30'd0, tl[11].stop_n, tl[11].frame_n}, 32'h1);
        chk("m_to_n12", {31'd0, tl[12].stop_n}, 32'h1);
        run();

        // Ready on the last allowed wait clock beats the timeout
        salt = 32'h55;
        gen(32'h20, 4'h6, 1, 7, 7, -1, 0);
        chk("m_race_trdy", {30'd0, tl[10].trdy_n, tl[10].stop_n}, 32'h1);
        run();

        // Burst write starting at the top word
        gen(32'hFFC, 4'hF, 3, 0, 0, -1, 0);
        n = 0;
        foreach (tl[i]) if (tl[i].we) n++;
        chk("m_top_one_we", 32'(n), 32'd1);
        chk("m_top_disc", {30'd0, tl[3].trdy_n, tl[3].stop_n}, 32'h0);
        chk("m_top_backoff", {29'd0, tl[4].devsel_n, tl[4].trdy_n, tl[4].stop_n}, 32'h2);
        run();

        // Reset in the middle of a read data phase, then a normal claim
        gen(32'h10, 4'hC, 3, 1, 2, -1, 4);
        chk("m_rst_release", {30'd0, tl[5].ctl_oe, tl[5].ad_oe}, 32'h0);
        run();
        gen(32'h10, 4'hC, 2, 0, 1, -1, 0);
        run();

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            salt = $urandom;
            addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if (r == 0) addr[31:12] = 20'($urandom_range(1, 20'hFFFFF));
            if (r == 1) addr[1:0] = 2'($urandom_range(1, 3));
            if (r == 2) addr[11:2] = 10'(1023 - $urandom_range(0, 3));
            cmd = cmds[$urandom_range(0, 4)];
            if (r == 3) cmd = 4'($urandom_range(0, 15));
            gen(addr, cmd, $urandom_range(1, 6), 0, (r == 4) ? 9 : 3, -1,
                (r == 5) ? $urandom_range(1, 8) : 0);
            run();
        end

        @(posedge CLK);
        cur_valid = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
